// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_fifo_pkg: shared sizing helpers and output-slot record. Rev 1.0
// ----------------------------------------------------------------------------
package ram_fifo_pkg;

    // Widest word the output slots can carry; narrower builds use the low bits.
    localparam int unsigned SLOT_DW_MAX = 64;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_DW_MAX-1:0] data;
    } slot_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int cnt_w(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_out_skid.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_out_skid: two-slot FWFT output buffer that absorbs the RAM read latency. Rev 1.0
// ----------------------------------------------------------------------------
module fifo_out_skid
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pend_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  m_ready_i,
    output logic [1:0]            occ_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o
);

    slot_t slot0_q;
    slot_t slot1_q;
    slot_t slot0_d;
    slot_t slot1_d;
    logic  pop;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        pop     = slot0_q.valid & m_ready_i;

        if (pop) begin
            slot0_d = slot1_q;
            slot1_d = '0;
        end

        // The issue rule upstream guarantees a free slot whenever a read lands.
        if (pend_i) begin
            if (!slot0_d.valid) begin
                slot0_d.valid = 1'b1;
                slot0_d.data  = SLOT_DW_MAX'(rd_data_i);
            end else begin
                slot1_d.valid = 1'b1;
                slot1_d.data  = SLOT_DW_MAX'(rd_data_i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign occ_o     = {1'b0, slot0_q.valid} + {1'b0, slot1_q.valid};
    assign m_valid_o = slot0_q.valid;
    assign m_data_o  = slot0_q.data[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_fifo_ctrl: valid/ready FIFO controller driving a dual-port RAM, FWFT pop side. Rev 1.0
// ----------------------------------------------------------------------------
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [cnt_w(ADDR_WIDTH)-1:0] count,
    output logic                         ram_we_a,
    output logic [ADDR_WIDTH-1:0]        ram_addr_a,
    output logic [DATA_WIDTH-1:0]        ram_din_a,
    output logic                         ram_we_b,
    output logic [ADDR_WIDTH-1:0]        ram_addr_b,
    input  logic [DATA_WIDTH-1:0]        ram_dout_b
);

    localparam int CNT_W = cnt_w(ADDR_WIDTH);
    localparam int RCW   = ADDR_WIDTH + 1;
    localparam logic [RCW-1:0] RAM_FULL = RCW'(fifo_depth(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
    logic [RCW-1:0]        ram_cnt_q, ram_cnt_d;
    logic                  pend_q,    pend_d;
    logic [CNT_W-1:0]      count_q,   count_d;

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [1:0] occ;
    logic [2:0] slots_claimed;

    assign s_ready = (ram_cnt_q < RAM_FULL);
    // Gated by rst_n so no write strobe reaches the RAM while reset is held.
    assign push    = s_valid & s_ready & rst_n;
    assign pop     = m_valid & m_ready;

    // Slots already taken or promised, net of the word leaving this cycle.
    assign slots_claimed = {1'b0, occ} + {2'b00, pend_q};
    assign rd_issue      = (ram_cnt_q != '0) && (slots_claimed < (3'd2 + {2'b00, pop}));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pend_d    = rd_issue;
        ram_cnt_d = ram_cnt_q + RCW'(push) - RCW'(rd_issue);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            pend_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            pend_q    <= pend_d;
            count_q   <= count_d;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .pend_i    (pend_q),
        .rd_data_i (ram_dout_b),
        .m_ready_i (m_ready),
        .occ_o     (occ),
        .m_valid_o (m_valid),
        .m_data_o  (m_data)
    );

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr_q;
    assign ram_din_a  = s_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr_q;
    assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a behavioural RAM. Rev 1.0
// ----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b = '0;

    ram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM; a same-address read during a write returns poisoned data.
    logic [DW-1:0] mem [DEPTH];
    int            collisions = 0;
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_we_a && ram_addr_a == ram_addr_b) begin
            ram_dout_b <= ~mem[ram_addr_b];
            collisions++;
        end else begin
            ram_dout_b <= mem[ram_addr_b];
        end
    end

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    int            cnt_model = 0;
    int            accepted = 0;
    int            popped = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic [DW-1:0] last_pop_data = '0;
    logic          last_pop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, score handshakes before the edge, check count after it.
    task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic do_push;
        logic do_pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        do_push  = s_valid & s_ready;
        do_pop   = m_valid & m_ready;
        last_pop = do_pop;
        if (stall_prev) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, data_prev);
        end
        if (cnt_model == CAP) chk("full_sready", s_ready, 1'b0);
        if (cnt_model < DEPTH) chk("room_sready", s_ready, 1'b1);
        if (!m_valid && m_ready) chk("empty_count", (cnt_model < 3) ? 1 : 0, 1);
        if (do_push) begin
            exp_q.push_back(sd);
            accepted++;
        end
        if (do_pop) begin
            popped++;
            last_pop_data = m_data;
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", m_data, exp_q.pop_front());
        end
        stall_prev = m_valid & ~m_ready;
        data_prev  = m_data;
        cnt_model  = cnt_model + int'(do_push) - int'(do_pop);
        @(posedge clk);
        #1;
        chk("count", count, cnt_model);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && cnt_model != 0; k++) cycle(1'b0, '0, 1'b1);
        chk("drain_count", count, 0);
        chk("drain_mvalid", m_valid, 1'b0);
        chk("drain_sb", exp_q.size(), 0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_mdata", m_data, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_sready", s_ready, 1'b1);
        chk("rst_we_a", ram_we_a, 1'b0);
        chk("we_b_low", ram_we_b, 1'b0);

        // Single word: latency and count sequence 1,1,1,0
        cycle(1'b1, 8'hA5, 1'b1);
        chk("sw_mvalid_e0", m_valid, 1'b0);
        chk("sw_count_e0", count, 1);
        cycle(1'b0, '0, 1'b1);
        chk("sw_mvalid_e1", m_valid, 1'b0);
        chk("sw_count_e1", count, 1);
        cycle(1'b0, '0, 1'b1);
        chk("sw_mvalid_e2", m_valid, 1'b1);
        chk("sw_mdata_e2", m_data, 8'hA5);
        chk("sw_count_e2", count, 1);
        cycle(1'b0, '0, 1'b1);
        chk("sw_mvalid_e3", m_valid, 1'b0);
        chk("sw_count_e3", count, 0);

        // Fill to capacity with the consumer stalled, then drain
        accepted = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(i), 1'b0);
        chk("fill_accepted", accepted, CAP);
        chk("fill_count", count, CAP);
        chk("fill_sready", s_ready, 1'b0);
        drain();
        chk("drain_sready", s_ready, 1'b1);

        // Streaming: full rate in and out
        popped = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DW'(8'h40 + i), 1'b1);
            if (i >= 3) chk("stream_nogap", last_pop, 1'b1);
            if (i >= 2) chk("stream_count", count, 3);
        end
        chk("stream_pops", popped, 37);
        drain();

        // Backpressure with m_ready pattern 1,0,0,1
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, DW'(8'h90 + i), ((i % 4) == 0) || ((i % 4) == 3));
        end
        drain();

        // Reset mid-stream
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0);
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("mid_rst_mvalid", m_valid, 1'b0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_sready", s_ready, 1'b1);
        chk("mid_rst_we_a", ram_we_a, 1'b0);
        exp_q.delete();
        cnt_model  = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_count", count, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        popped = 0;
        cycle(1'b1, 8'h5A, 1'b1);
        for (int k = 0; k < 10 && popped == 0; k++) cycle(1'b0, '0, 1'b1);
        chk("post_rst_first", last_pop_data, 8'h5A);
        chk("post_rst_popped", popped, 1);

        // Random traffic; RAM poisoning exposes any captured port collision
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
